// File: rtl/memory_game.sv
// memory_game -- sequence-recall game controller.
//
// Each round appends one random digit (0-9, folded from the 4-bit rnd input)
// to a stored sequence, plays the whole sequence out digit by digit, then
// checks the player's key entries against it. A fully correct sequence starts
// the next round; a wrong key or an input timeout loses; reaching MAX_LEN wins.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset (0 = reset)
//   rnd          random digit source, sampled in APPEND
//   start        level-sampled start / restart request (IDLE, WIN, LOSE only)
//   key_valid    one-cycle key strobe, evaluated only in INPUT
//   key_digit    key value accompanying key_valid
//   show_valid   high while a sequence digit is displayed
//   show_digit   displayed digit, 0 when show_valid is low
//   input_ready  high while waiting for player keys
//   level        current sequence length
//   win / lose   one-cycle pulses on entry to WIN / LOSE
//   game_over    high in WIN or LOSE
module memory_game #(
  parameter int MAX_LEN       = 8,
  parameter int SHOW_TICKS    = 50_000_000,
  parameter int GAP_TICKS     = 12_500_000,
  parameter int TIMEOUT_TICKS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rnd,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       show_valid,
  output logic [3:0] show_digit,
  output logic       input_ready,
  output logic [3:0] level,
  output logic       win,
  output logic       lose,
  output logic       game_over
);

  // Tick counter only ever counts up to (longest interval - 1).
  localparam int MAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int MAX_B = (MAX_A > TIMEOUT_TICKS) ? MAX_A : TIMEOUT_TICKS;
  localparam int MAX_T = (MAX_B > 2) ? MAX_B : 2;
  localparam int TW    = $clog2(MAX_T);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_TICKS > 0) ? (TIMEOUT_TICKS - 1) : 0);
  localparam logic [3:0]    MAX_LEN_L = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          show_valid_q, show_valid_d;
  logic [3:0]    show_digit_q, show_digit_d;
  logic          input_ready_q, input_ready_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          game_over_q, game_over_d;

  // Sequence storage; only entries below len are ever meaningful.
  logic [3:0] mem [0:15];
  logic       mem_we;
  logic [3:0] norm_digit;
  logic [3:0] idx_inc;
  logic       key_match;
  logic       last_key;

  // Fold 10..15 down to 0..5 so the stored sequence is always decimal.
  assign norm_digit = (rnd > 4'd9) ? (rnd - 4'd10) : rnd;
  assign idx_inc    = idx_q + 4'd1;
  // Stored digits are never above 9, so keys above 9 can never match.
  assign key_match  = (key_digit == mem[idx_q]);
  assign last_key   = (idx_q == (len_q - 4'd1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    tick_d        = tick_q;
    show_valid_d  = show_valid_q;
    show_digit_d  = show_digit_q;
    input_ready_d = input_ready_q;
    win_d         = 1'b0;
    lose_d        = 1'b0;
    game_over_d   = game_over_q;
    mem_we        = 1'b0;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d       = S_APPEND;
          len_d         = 4'd0;
          idx_d         = 4'd0;
          tick_d        = '0;
          show_valid_d  = 1'b0;
          show_digit_d  = 4'd0;
          input_ready_d = 1'b0;
          game_over_d   = 1'b0;
        end
      end

      S_APPEND: begin
        mem_we       = 1'b1;
        len_d        = len_q + 4'd1;
        idx_d        = 4'd0;
        tick_d       = '0;
        state_d      = S_SHOW_ON;
        show_valid_d = 1'b1;
        // mem[0] is being written this very edge on the first round,
        // so forward the incoming digit instead of reading stale memory.
        show_digit_d = (len_q == 4'd0) ? norm_digit : mem[0];
      end

      S_SHOW_ON: begin
        if (tick_q == SHOW_LAST) begin
          tick_d       = '0;
          state_d      = S_SHOW_GAP;
          show_valid_d = 1'b0;
          show_digit_d = 4'd0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_SHOW_GAP: begin
        if (tick_q == GAP_LAST) begin
          tick_d = '0;
          if (idx_inc == len_q) begin
            idx_d         = 4'd0;
            state_d       = S_INPUT;
            input_ready_d = 1'b1;
          end else begin
            idx_d        = idx_inc;
            state_d      = S_SHOW_ON;
            show_valid_d = 1'b1;
            show_digit_d = mem[idx_inc];
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_INPUT: begin
        if (key_valid) begin
          tick_d = '0;
          if (!key_match) begin
            state_d       = S_LOSE;
            input_ready_d = 1'b0;
            lose_d        = 1'b1;
            game_over_d   = 1'b1;
          end else if (last_key) begin
            input_ready_d = 1'b0;
            if (len_q == MAX_LEN_L) begin
              state_d     = S_WIN;
              win_d       = 1'b1;
              game_over_d = 1'b1;
            end else begin
              state_d = S_APPEND;
            end
          end else begin
            idx_d = idx_inc;
          end
        end else if (TIMEOUT_TICKS > 0) begin
          if (tick_q == TO_LAST) begin
            state_d       = S_LOSE;
            input_ready_d = 1'b0;
            lose_d        = 1'b1;
            game_over_d   = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= 4'd0;
      idx_q         <= 4'd0;
      tick_q        <= '0;
      show_valid_q  <= 1'b0;
      show_digit_q  <= 4'd0;
      input_ready_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      tick_q        <= tick_d;
      show_valid_q  <= show_valid_d;
      show_digit_q  <= show_digit_d;
      input_ready_q <= input_ready_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      game_over_q   <= game_over_d;
    end
  end

  // Memory carries no reset; its contents are irrelevant until written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[len_q] <= norm_digit;
    end
  end

  assign show_valid  = show_valid_q;
  assign show_digit  = show_digit_q;
  assign input_ready = input_ready_q;
  assign level       = len_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_memory_game.sv
// tb_memory_game -- bench for memory_game.
//
// Two instances share all inputs: dut 0 with the input timeout disabled and
// dut 1 with a 5-cycle timeout. A game-level model (sequence array, elapsed
// time within the playback, key position) predicts every output each cycle;
// directed checks with literal values pin the key timing points.
module tb_memory_game;

  localparam int ML  = 3;
  localparam int ST  = 4;
  localparam int GT  = 2;
  localparam int PER = ST + GT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] rnd = 4'd0;
  logic [3:0] key_digit = 4'd0;

  logic       show_valid_o  [2];
  logic [3:0] show_digit_o  [2];
  logic       input_ready_o [2];
  logic [3:0] level_o       [2];
  logic       win_o         [2];
  logic       lose_o        [2];
  logic       game_over_o   [2];

  always #5 clk = ~clk;

  memory_game #(.MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(0)) dut0 (
    .clk(clk), .reset(reset), .rnd(rnd), .start(start),
    .key_valid(key_valid), .key_digit(key_digit),
    .show_valid(show_valid_o[0]), .show_digit(show_digit_o[0]),
    .input_ready(input_ready_o[0]), .level(level_o[0]),
    .win(win_o[0]), .lose(lose_o[0]), .game_over(game_over_o[0])
  );

  memory_game #(.MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(5)) dut1 (
    .clk(clk), .reset(reset), .rnd(rnd), .start(start),
    .key_valid(key_valid), .key_digit(key_digit),
    .show_valid(show_valid_o[1]), .show_digit(show_digit_o[1]),
    .input_ready(input_ready_o[1]), .level(level_o[1]),
    .win(win_o[1]), .lose(lose_o[1]), .game_over(game_over_o[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- game-level model ----------------
  localparam int M_IDLE = 0, M_APPEND = 1, M_PLAY = 2, M_INPUT = 3, M_WIN = 4, M_LOSE = 5;

  int mode [2];
  int mlen [2];
  int pos  [2];
  int t    [2];   // PLAY: cycles since playback began; INPUT: idle cycles
  bit ent  [2];   // WIN/LOSE entered on the last edge
  int seq  [2][16];
  bit cmp_en = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = M_IDLE; mlen[k] = 0; pos[k] = 0; t[k] = 0; ent[k] = 1'b0;
    end
  end

  function automatic int to_of(input int k);
    return (k == 1) ? 5 : 0;
  endfunction

  task automatic step(input int k);
    ent[k] = 1'b0;
    if (!reset) begin
      mode[k] = M_IDLE; mlen[k] = 0; pos[k] = 0; t[k] = 0;
    end else begin
      case (mode[k])
        M_IDLE, M_WIN, M_LOSE: begin
          if (start) begin
            mlen[k] = 0;
            mode[k] = M_APPEND;
          end
        end
        M_APPEND: begin
          seq[k][mlen[k]] = int'(rnd) % 10;
          mlen[k]++;
          t[k] = 0;
          mode[k] = M_PLAY;
        end
        M_PLAY: begin
          t[k]++;
          if (t[k] == mlen[k] * PER) begin
            mode[k] = M_INPUT; pos[k] = 0; t[k] = 0;
          end
        end
        M_INPUT: begin
          if (key_valid) begin
            if (int'(key_digit) != seq[k][pos[k]]) begin
              mode[k] = M_LOSE; ent[k] = 1'b1;
            end else if (pos[k] == mlen[k] - 1) begin
              if (mlen[k] == ML) begin
                mode[k] = M_WIN; ent[k] = 1'b1;
              end else begin
                mode[k] = M_APPEND;
              end
            end else begin
              pos[k]++; t[k] = 0;
            end
          end else if (to_of(k) > 0) begin
            t[k]++;
            if (t[k] == to_of(k)) begin
              mode[k] = M_LOSE; ent[k] = 1'b1;
            end
          end
        end
        default: mode[k] = M_IDLE;
      endcase
    end
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
    if (!reset) cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int e_sv;
        int e_sd;
        e_sv = 0;
        e_sd = 0;
        if (mode[k] == M_PLAY && (t[k] % PER) < ST) begin
          e_sv = 1;
          e_sd = seq[k][t[k] / PER];
        end
        check($sformatf("dut%0d show_valid", k), show_valid_o[k], e_sv);
        check($sformatf("dut%0d show_digit", k), show_digit_o[k], e_sd);
        check($sformatf("dut%0d input_ready", k), input_ready_o[k], (mode[k] == M_INPUT) ? 1 : 0);
        check($sformatf("dut%0d level", k), level_o[k], mlen[k]);
        check($sformatf("dut%0d win", k), win_o[k], (mode[k] == M_WIN && ent[k]) ? 1 : 0);
        check($sformatf("dut%0d lose", k), lose_o[k], (mode[k] == M_LOSE && ent[k]) ? 1 : 0);
        check($sformatf("dut%0d game_over", k), game_over_o[k],
              (mode[k] == M_WIN || mode[k] == M_LOSE) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_input(input string name);
    int n;
    n = 0;
    while (input_ready_o[0] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(name, input_ready_o[0], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int exp_sv [7];
    int shown;
    int digs [$];
    logic prev;
    exp_sv = '{1, 1, 1, 1, 0, 0, 0};

    // Reset held with start high: everything stays zero.
    reset = 1'b0; start = 1'b1; rnd = 4'd7;
    tick(); tick();
    check("reset show_valid", show_valid_o[0], 0);
    check("reset level", level_o[0], 0);
    check("reset input_ready", input_ready_o[0], 0);
    check("reset game_over", game_over_o[0], 0);

    // Release with start high: edge N sees start, APPEND in N+1.
    reset = 1'b1;
    tick();
    start = 1'b0;
    check("append level", level_o[0], 0);
    check("append show_valid", show_valid_o[0], 0);
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("r1 show_valid c%0d", c + 2), show_valid_o[0], exp_sv[c]);
      check($sformatf("r1 show_digit c%0d", c + 2), show_digit_o[0], exp_sv[c] ? 7 : 0);
      check($sformatf("r1 input_ready c%0d", c + 2), input_ready_o[0], (c == 6) ? 1 : 0);
    end
    check("r1 level", level_o[0], 1);

    // Full win: rnd 7, 12, 3 -> stored 7, 2, 3.
    rnd = 4'd12;
    press(7);
    wait_input("r2 input");
    check("r2 level", level_o[0], 2);
    press(7);
    rnd = 4'd3;
    press(2);
    shown = 0;
    prev  = 1'b0;
    for (int n = 0; n < 200 && input_ready_o[0] !== 1'b1; n++) begin
      tick();
      if (show_valid_o[0] === 1'b1) begin
        shown++;
        if (!prev) digs.push_back(int'(show_digit_o[0]));
      end
      prev = show_valid_o[0];
    end
    check("r3 shown cycles", shown, 12);
    check("r3 digit count", digs.size(), 3);
    check("r3 digit 0", digs[0], 7);
    check("r3 digit 1", digs[1], 2);
    check("r3 digit 2", digs[2], 3);
    check("r3 input", input_ready_o[0], 1);
    press(7);
    press(2);
    press(3);
    check("win pulse", win_o[0], 1);
    check("win game_over", game_over_o[0], 1);
    check("win level", level_o[0], 3);
    tick();
    check("win pulse end", win_o[0], 0);
    check("win hold", game_over_o[0], 1);
    tick(); tick();

    // Restart from WIN, then mismatch in round 2.
    rnd = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart game_over", game_over_o[0], 0);
    check("restart level", level_o[0], 0);
    tick();
    check("restart level after append", level_o[0], 1);
    check("restart digit", show_digit_o[0], 7);
    rnd = 4'd2;
    wait_input("m1 input");
    press(7);
    wait_input("m2 input");
    press(7);
    press(5);
    check("mismatch lose", lose_o[0], 1);
    check("mismatch game_over", game_over_o[0], 1);
    tick();
    check("lose pulse end", lose_o[0], 0);
    press(7);
    check("ignored key game_over", game_over_o[0], 1);
    check("ignored key level", level_o[0], 2);
    check("ignored key lose", lose_o[0], 0);

    // Timeout on dut1, invalid key on dut0 (restart from LOSE).
    rnd = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lose restart game_over", game_over_o[0], 0);
    wait_input("to input");
    for (int i = 0; i < 4; i++) tick();
    check("to not yet", input_ready_o[1], 1);
    tick();
    check("to lose", lose_o[1], 1);
    check("to game_over", game_over_o[1], 1);
    check("no-timeout still waiting", input_ready_o[0], 1);
    press(12);
    check("invalid key lose", lose_o[0], 1);
    check("invalid key game_over", game_over_o[0], 1);

    // Mid-game reset during SHOW_ON.
    rnd = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre-reset show", show_valid_o[0], 1);
    check("pre-reset digit", show_digit_o[0], 9);
    reset = 1'b0;
    tick();
    check("mid reset show_valid", show_valid_o[0], 0);
    check("mid reset digit", show_digit_o[0], 0);
    check("mid reset level", level_o[0], 0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("idle after reset level", level_o[0], 0);
    check("idle after reset show", show_valid_o[0], 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_game.md
# memory_game

Sequence-recall game controller: the consumer side of the `random_digit` generator. Each round it appends one sampled random digit (0–9) to a stored sequence and plays the whole sequence out, one digit at a time, for the 7-segment display path. It then accepts the player's key entries and compares them against the stored sequence. A full correct sequence advances the level; a wrong key or a timeout ends the game; reaching `MAX_LEN` wins it.

## Interface
- `MAX_LEN`, 8, sequence length needed to win (1–15)
- `SHOW_TICKS`, 50_000_000, cycles each digit is shown (≥1)
- `GAP_TICKS`, 12_500_000, blank cycles after each shown digit (≥1)
- `TIMEOUT_TICKS`, 0, max cycles between keys in input phase; 0 disables the timeout
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `rnd`  in  4  digit from `random_digit`, sampled in APPEND
- `start`  in  1  level-sampled start/restart request
- `key_valid`  in  1  one-cycle strobe, player key pressed
- `key_digit`  in  4  key value, valid with `key_valid`
- `show_valid`  out  1  high while a sequence digit is being displayed
- `show_digit`  out  4  digit being displayed; 0 when `show_valid`=0
- `input_ready`  out  1  high in INPUT state
- `level`  out  4  current sequence length
- `win`  out  1  one-cycle pulse on entry to WIN
- `lose`  out  1  one-cycle pulse on entry to LOSE
- `game_over`  out  1  high in WIN or LOSE

## Operation
- **States:** IDLE, APPEND, SHOW_ON, SHOW_GAP, INPUT, WIN, LOSE.
- **Reset** (`reset`=0 at a clock edge):
  - state = IDLE; `len` = 0; `idx` = 0; tick counter = 0.
  - All outputs are 0.
  - Memory contents are don't-care.
  - Reset overrides everything, mid-round included.
- **IDLE, WIN, LOSE:** when `start`=1, clear `len` → APPEND. With no `start`, WIN and LOSE hold.
- **APPEND** (1 cycle):
  - Store into `mem[len]`: `rnd` if `rnd`≤9, else `rnd`−10.
  - `len` += 1; `idx` = 0 → SHOW_ON.
- **SHOW_ON:**
  - Outputs: `show_valid`=1, `show_digit`=`mem[idx]`.
  - Lasts exactly `SHOW_TICKS` cycles → SHOW_GAP.
- **SHOW_GAP:**
  - Outputs: `show_valid`=0 for `GAP_TICKS` cycles.
  - Then `idx` += 1. If new `idx`==`len`: `idx`=0 → INPUT; else → SHOW_ON.
- **INPUT:** `input_ready`=1. On `key_valid`:
  - `key_digit`≠`mem[idx]` (including any value >9) → LOSE.
  - Match and `idx`<`len`−1 → `idx` += 1.
  - Match and `idx`==`len`−1: if `len`==`MAX_LEN` → WIN, else → APPEND.
- **Input timeout:** if `TIMEOUT_TICKS`>0 and `TIMEOUT_TICKS` cycles pass in INPUT without `key_valid` → LOSE. The tick counter restarts on every `key_valid` and on INPUT entry.
- **Ignored inputs:**
  - `key_valid` is ignored outside INPUT.
  - `start` is ignored in APPEND, SHOW_ON, SHOW_GAP and INPUT; there is no abort except reset.
- **Width rules:**
  - `level` = `len` (0..`MAX_LEN`).
  - Tick counter width = clog2(max(`SHOW_TICKS`, `GAP_TICKS`, `TIMEOUT_TICKS`, 2)).
  - `idx` never exceeds `len`−1 when memory is read.

## Timing
- All outputs are registered and change only on a `clk` rising edge.
- **Round latency:** if `start` is seen at edge N:
  - APPEND occupies cycle N+1; `mem[0]` is written at edge N+1.
  - `show_valid`=1 during cycles N+2 … N+1+`SHOW_TICKS`.
- **Per-digit display period** = `SHOW_TICKS`+`GAP_TICKS` cycles. INPUT starts on the cycle after the last gap cycle.
- **Key handling:** a key arriving at edge K updates the state at edge K.
  - `lose`/`win` pulse during cycle K+1; `game_over`=1 from K+1.
  - A correct final key at edge K puts APPEND in cycle K+1.
- **Back-to-back keys:** `key_valid` on consecutive cycles is legal, and each strobe is evaluated.
- **Timeout:** LOSE is entered at the edge that completes the `TIMEOUT_TICKS`-th idle cycle.
- **Restart:** `start` held high in WIN/LOSE causes APPEND on the next cycle and clears `game_over`.

## Test plan
Parameters unless stated: `MAX_LEN`=3, `SHOW_TICKS`=4, `GAP_TICKS`=2, `TIMEOUT_TICKS`=0.
- **Reset:** `reset`=0 for 2 cycles with `start`=1 → all outputs 0 and state IDLE. Release → APPEND on the next cycle.
- **Round 1 and display timing:** `rnd`=7, `start` pulse at edge N:
  - `show_valid`=1 with `show_digit`=7 for cycles N+2..N+5.
  - `show_valid`=0 for N+6..N+7.
  - `input_ready`=1 at N+8; `level`=1.
- **Full win:** drive `rnd`=7, 12, 3 across the APPEND cycles; key back the correct sequence each round.
  - Stored digits are 7, 2, 3.
  - Round 3 shows 7,2,3 (`show_valid` high 3×4 cycles).
  - After the final correct key: `win` pulses once, `game_over`=1, `level`=3.
- **Mismatch:** in round 2 (seq 7,2), key 7 then 5 → `lose` pulse one cycle after the 5, `game_over`=1. A later `key_valid` changes nothing.
- **Timeout and invalid key:** with `TIMEOUT_TICKS`=5, no key for 5 cycles in INPUT → `lose`. Separately, key 12 in INPUT → `lose`.
- **Mid-game reset and restart:** `reset`=0 during SHOW_ON → outputs 0 next cycle and `level`=0. From LOSE, `start`=1 → `game_over`=0, APPEND, `level`=1.
